// File: rtl/idex_pipeline_stage.sv
// idex_pipeline_stage: ID/EX pipeline register with load-use hazard detection.
// Latches the decoded control bundle, operands, immediate and register
// specifiers. Inserts a bubble on a load-use hazard or a branch/jump flush,
// and freezes PC and IF/ID while the stall is requested.
// Optional feature: define IDEX_PERF_CNT_EN to add saturating 16-bit
// StallCount / FlushCount performance counters and their ports.
module idex_pipeline_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  WriteEnable,
    input  logic                  Flush,
    input  logic [17:0]           CtrlIn,
    input  logic [DATA_W-1:0]     PCPlus4In,
    input  logic [DATA_W-1:0]     ReadData1In,
    input  logic [DATA_W-1:0]     ReadData2In,
    input  logic [DATA_W-1:0]     ImmIn,
    input  logic [REG_ADDR_W-1:0] RsIn,
    input  logic [REG_ADDR_W-1:0] RtIn,
    input  logic [REG_ADDR_W-1:0] RdIn,
    output logic [17:0]           CtrlOut,
    output logic [DATA_W-1:0]     PCPlus4Out,
    output logic [DATA_W-1:0]     ReadData1Out,
    output logic [DATA_W-1:0]     ReadData2Out,
    output logic [DATA_W-1:0]     ImmOut,
    output logic [REG_ADDR_W-1:0] RsOut,
    output logic [REG_ADDR_W-1:0] RtOut,
    output logic [REG_ADDR_W-1:0] RdOut,
    output logic                  ExValid,
    output logic                  Stall,
    output logic                  PCWrite,
    output logic                  IFIDWrite
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [15:0]           StallCount,
    output logic [15:0]           FlushCount
`endif
);

    // Position of MemRead inside the packed control bundle.
    localparam int MEM_READ_BIT = 14;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [17:0]             ctrl_reg, ctrl_next;
    logic [DATA_W-1:0]       pc_plus4_reg, pc_plus4_next;
    logic [DATA_W-1:0]       rd1_reg, rd1_next;
    logic [DATA_W-1:0]       rd2_reg, rd2_next;
    logic [DATA_W-1:0]       imm_reg, imm_next;
    logic [REG_ADDR_W-1:0]   rs_reg, rs_next;
    logic [REG_ADDR_W-1:0]   rt_reg, rt_next;
    logic [REG_ADDR_W-1:0]   rd_reg, rd_next;
    logic                    ex_valid_reg, ex_valid_next;
    logic                    hazard;
    logic                    stall;

    // Load in EX whose destination (Rt) is read by the decode instruction.
    // Rt is always compared, even for instructions that do not read it.
    assign hazard = ctrl_reg[MEM_READ_BIT] & ex_valid_reg
                  & (rt_reg != '0)
                  & ((rt_reg == RsIn) | (rt_reg == RtIn));

    // A flush already discards the decode instruction, so no stall then;
    // a disabled stage holds everything and re-evaluates later.
    assign stall     = hazard & WriteEnable & ~Flush;
    assign Stall     = stall;
    assign PCWrite   = ~stall;
    assign IFIDWrite = ~stall;

    // Next-state selection: flush > hold > bubble > normal load.
    always_comb begin
        state_next    = state_reg;
        ctrl_next     = ctrl_reg;
        pc_plus4_next = pc_plus4_reg;
        rd1_next      = rd1_reg;
        rd2_next      = rd2_reg;
        imm_next      = imm_reg;
        rs_next       = rs_reg;
        rt_next       = rt_reg;
        rd_next       = rd_reg;
        ex_valid_next = ex_valid_reg;
        if (Flush) begin
            state_next    = BUBBLE;
            ctrl_next     = '0;
            ex_valid_next = 1'b0;
            pc_plus4_next = PCPlus4In;
            rd1_next      = ReadData1In;
            rd2_next      = ReadData2In;
            imm_next      = ImmIn;
            rs_next       = RsIn;
            rt_next       = RtIn;
            rd_next       = RdIn;
        end else if (!WriteEnable) begin
            state_next    = state_reg;
        end else if (stall) begin
            // Bubble: squash control, keep the data fields as they are.
            state_next    = BUBBLE;
            ctrl_next     = '0;
            ex_valid_next = 1'b0;
        end else begin
            state_next    = RUN;
            ctrl_next     = CtrlIn;
            ex_valid_next = 1'b1;
            pc_plus4_next = PCPlus4In;
            rd1_next      = ReadData1In;
            rd2_next      = ReadData2In;
            imm_next      = ImmIn;
            rs_next       = RsIn;
            rt_next       = RtIn;
            rd_next       = RdIn;
        end
    end

    // Pipeline register and bubble-state register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg    <= RUN;
            ctrl_reg     <= '0;
            pc_plus4_reg <= '0;
            rd1_reg      <= '0;
            rd2_reg      <= '0;
            imm_reg      <= '0;
            rs_reg       <= '0;
            rt_reg       <= '0;
            rd_reg       <= '0;
            ex_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ctrl_reg     <= ctrl_next;
            pc_plus4_reg <= pc_plus4_next;
            rd1_reg      <= rd1_next;
            rd2_reg      <= rd2_next;
            imm_reg      <= imm_next;
            rs_reg       <= rs_next;
            rt_reg       <= rt_next;
            rd_reg       <= rd_next;
            ex_valid_reg <= ex_valid_next;
        end
    end

    assign CtrlOut      = ctrl_reg;
    assign PCPlus4Out   = pc_plus4_reg;
    assign ReadData1Out = rd1_reg;
    assign ReadData2Out = rd2_reg;
    assign ImmOut       = imm_reg;
    assign RsOut        = rs_reg;
    assign RtOut        = rt_reg;
    assign RdOut        = rd_reg;
    assign ExValid      = ex_valid_reg;

`ifdef IDEX_PERF_CNT_EN
    logic [15:0] stall_count_reg;
    logic [15:0] flush_count_reg;

    // Saturating event counters for hazard bubbles and flushes.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            if (stall && (stall_count_reg != 16'hFFFF)) begin
                stall_count_reg <= stall_count_reg + 16'd1;
            end
            if (Flush && (flush_count_reg != 16'hFFFF)) begin
                flush_count_reg <= flush_count_reg + 16'd1;
            end
        end
    end

    assign StallCount = stall_count_reg;
    assign FlushCount = flush_count_reg;
`endif

endmodule

// File: tb/tb_idex_pipeline_stage.sv
// Testbench for idex_pipeline_stage: directed vector table, hand-written
// reset/hold sequences and a randomized run against a behavioural model.
module tb_idex_pipeline_stage;

    localparam logic [17:0] ADDI = 18'h01802;
    localparam logic [17:0] LW   = 18'h05882;
    localparam logic [17:0] ADD  = 18'h01200;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        WriteEnable, Flush;
    logic [17:0] CtrlIn;
    logic [31:0] PCPlus4In, ReadData1In, ReadData2In, ImmIn;
    logic [4:0]  RsIn, RtIn, RdIn;
    logic [17:0] CtrlOut;
    logic [31:0] PCPlus4Out, ReadData1Out, ReadData2Out, ImmOut;
    logic [4:0]  RsOut, RtOut, RdOut;
    logic        ExValid, Stall, PCWrite, IFIDWrite;
`ifdef IDEX_PERF_CNT_EN
    logic [15:0] StallCount, FlushCount;
`endif

    int tests = 0;
    int fails = 0;

    idex_pipeline_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .Clk(Clk), .Rst(Rst), .WriteEnable(WriteEnable), .Flush(Flush),
        .CtrlIn(CtrlIn), .PCPlus4In(PCPlus4In), .ReadData1In(ReadData1In),
        .ReadData2In(ReadData2In), .ImmIn(ImmIn),
        .RsIn(RsIn), .RtIn(RtIn), .RdIn(RdIn),
        .CtrlOut(CtrlOut), .PCPlus4Out(PCPlus4Out), .ReadData1Out(ReadData1Out),
        .ReadData2Out(ReadData2Out), .ImmOut(ImmOut),
        .RsOut(RsOut), .RtOut(RtOut), .RdOut(RdOut),
        .ExValid(ExValid), .Stall(Stall), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite)
`ifdef IDEX_PERF_CNT_EN
        , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic        fl;
        logic [17:0] ctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rd1;
        logic        exp_stall;
        logic [17:0] exp_ctrl;
        logic        exp_valid;
        logic [31:0] exp_rd1;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(logic we, logic fl, logic [17:0] ctrl, logic [4:0] rs,
                                logic [4:0] rt, logic [31:0] rd1, logic es,
                                logic [17:0] ec, logic ev, logic [31:0] er);
        vec_t v;
        v.we = we; v.fl = fl; v.ctrl = ctrl; v.rs = rs; v.rt = rt; v.rd1 = rd1;
        v.exp_stall = es; v.exp_ctrl = ec; v.exp_valid = ev; v.exp_rd1 = er;
        return v;
    endfunction

    // Behavioural model of the EX slot contents.
    logic [17:0] m_ctrl;
    logic [31:0] m_pc, m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic        m_valid;
    int          m_stalls, m_flushes;

    task automatic model_reset();
        m_ctrl = '0; m_pc = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
        m_rs = '0; m_rt = '0; m_rd = '0; m_valid = 1'b0;
        m_stalls = 0; m_flushes = 0;
    endtask

    function automatic logic model_stall();
        return m_valid && m_ctrl[14] && (m_rt != 5'd0) &&
               ((m_rt == RsIn) || (m_rt == RtIn)) && WriteEnable && !Flush;
    endfunction

    task automatic load_inputs_into_model();
        m_pc = PCPlus4In; m_rd1 = ReadData1In; m_rd2 = ReadData2In; m_imm = ImmIn;
        m_rs = RsIn; m_rt = RtIn; m_rd = RdIn;
    endtask

    task automatic set_in(logic we, logic fl, logic [17:0] ctrl, logic [4:0] rs,
                          logic [4:0] rt, logic [31:0] rd1);
        WriteEnable = we; Flush = fl; CtrlIn = ctrl; RsIn = rs; RtIn = rt;
        ReadData1In = rd1; RdIn = 5'($urandom);
        PCPlus4In = $urandom; ReadData2In = $urandom; ImmIn = $urandom;
    endtask

    logic        exp_stall;
    logic [31:0] held_rd1;

    initial begin
        // Reset with random inputs: everything cleared, stall released.
        Rst = 1'b1;
        set_in(1'($urandom), 1'($urandom), 18'($urandom), 5'($urandom), 5'($urandom), $urandom);
        #2;
        chk("rst_ctrl", 32'(CtrlOut), 32'h0);
        chk("rst_valid", 32'(ExValid), 32'h0);
        chk("rst_rd1", ReadData1Out, 32'h0);
        chk("rst_imm", ImmOut, 32'h0);
        chk("rst_stall", 32'(Stall), 32'h0);
        chk("rst_pcwrite", 32'(PCWrite), 32'h1);
        chk("rst_ifidwrite", 32'(IFIDWrite), 32'h1);
        Rst = 1'b0;

        // Directed table: load, load-use, $zero, flush+hazard, hold.
        tbl[0]  = mk(1, 0, ADDI, 1, 2, 32'd5,   0, ADDI, 1, 32'd5);
        tbl[1]  = mk(1, 0, LW,   1, 8, 32'd101, 0, LW,   1, 32'd101);
        tbl[2]  = mk(1, 0, ADD,  8, 9, 32'd102, 1, '0,   0, 32'd101);
        tbl[3]  = mk(1, 0, ADD,  8, 9, 32'd103, 0, ADD,  1, 32'd103);
        tbl[4]  = mk(1, 0, LW,   0, 0, 32'd104, 0, LW,   1, 32'd104);
        tbl[5]  = mk(1, 0, ADD,  0, 0, 32'd105, 0, ADD,  1, 32'd105);
        tbl[6]  = mk(1, 0, LW,   2, 3, 32'd106, 0, LW,   1, 32'd106);
        tbl[7]  = mk(1, 1, ADD,  3, 3, 32'd107, 0, '0,   0, 32'd107);
        tbl[8]  = mk(1, 0, ADD,  3, 3, 32'd108, 0, ADD,  1, 32'd108);
        tbl[9]  = mk(1, 0, LW,   1, 4, 32'd109, 0, LW,   1, 32'd109);
        tbl[10] = mk(0, 0, ADD,  4, 6, 32'd110, 0, LW,   1, 32'd109);
        tbl[11] = mk(1, 0, ADD,  5, 4, 32'd111, 1, '0,   0, 32'd109);
        tbl[12] = mk(1, 0, ADD,  5, 4, 32'd112, 0, ADD,  1, 32'd112);

        for (int i = 0; i < 13; i++) begin
            set_in(tbl[i].we, tbl[i].fl, tbl[i].ctrl, tbl[i].rs, tbl[i].rt, tbl[i].rd1);
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(Stall), 32'(tbl[i].exp_stall));
            chk($sformatf("vec%0d_pcwrite", i), 32'(PCWrite), 32'(!tbl[i].exp_stall));
            @(posedge Clk); #1;
            chk($sformatf("vec%0d_ctrl", i), 32'(CtrlOut), 32'(tbl[i].exp_ctrl));
            chk($sformatf("vec%0d_valid", i), 32'(ExValid), 32'(tbl[i].exp_valid));
            chk($sformatf("vec%0d_rd1", i), ReadData1Out, tbl[i].exp_rd1);
        end

        // Reset asserted mid-stall clears the bubble; next edge loads normally.
        set_in(1, 0, LW, 1, 8, 32'd1);
        @(posedge Clk); #1;
        set_in(1, 0, ADD, 8, 2, 32'h1234);
        #1;
        chk("midrst_stall_before", 32'(Stall), 32'h1);
        Rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(ExValid), 32'h0);
        chk("midrst_stall", 32'(Stall), 32'h0);
        chk("midrst_ctrl", 32'(CtrlOut), 32'h0);
        Rst = 1'b0;
        @(posedge Clk); #1;
        chk("postrst_ctrl", 32'(CtrlOut), 32'(ADD));
        chk("postrst_valid", 32'(ExValid), 32'h1);
        chk("postrst_rd1", ReadData1Out, 32'h1234);

        // Hold for three cycles with changing inputs.
        held_rd1 = ReadData1Out;
        for (int k = 0; k < 3; k++) begin
            set_in(0, 0, 18'($urandom), 5'($urandom), 5'($urandom), $urandom);
            @(posedge Clk); #1;
            chk($sformatf("hold%0d_ctrl", k), 32'(CtrlOut), 32'(ADD));
            chk($sformatf("hold%0d_valid", k), 32'(ExValid), 32'h1);
            chk($sformatf("hold%0d_rd1", k), ReadData1Out, held_rd1);
        end

        // Randomized run against the behavioural model.
        Rst = 1'b1; #1; Rst = 1'b0;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            WriteEnable = ($urandom_range(0, 9) != 0);
            Flush       = ($urandom_range(0, 9) == 0);
            CtrlIn      = 18'($urandom);
            if ($urandom_range(0, 1) == 1) CtrlIn[14] = 1'b1;
            RsIn = 5'($urandom_range(0, 3));
            RtIn = 5'($urandom_range(0, 3));
            RdIn = 5'($urandom);
            PCPlus4In = $urandom; ReadData1In = $urandom;
            ReadData2In = $urandom; ImmIn = $urandom;
            #1;
            exp_stall = model_stall();
            chk("rnd_stall", 32'(Stall), 32'(exp_stall));
            chk("rnd_pcwrite", 32'(PCWrite), 32'(!exp_stall));
            chk("rnd_ifidwrite", 32'(IFIDWrite), 32'(!exp_stall));
            @(posedge Clk);
            if (Flush) begin
                m_ctrl = '0; m_valid = 1'b0; load_inputs_into_model();
                m_flushes++;
            end else if (!WriteEnable) begin
                // hold
            end else if (exp_stall) begin
                m_ctrl = '0; m_valid = 1'b0;
                m_stalls++;
            end else begin
                m_ctrl = CtrlIn; m_valid = 1'b1; load_inputs_into_model();
            end
            #1;
            chk("rnd_ctrl", 32'(CtrlOut), 32'(m_ctrl));
            chk("rnd_valid", 32'(ExValid), 32'(m_valid));
            chk("rnd_pc", PCPlus4Out, m_pc);
            chk("rnd_rd1", ReadData1Out, m_rd1);
            chk("rnd_rd2", ReadData2Out, m_rd2);
            chk("rnd_imm", ImmOut, m_imm);
            chk("rnd_rs", 32'(RsOut), 32'(m_rs));
            chk("rnd_rt", 32'(RtOut), 32'(m_rt));
            chk("rnd_rd", 32'(RdOut), 32'(m_rd));
`ifdef IDEX_PERF_CNT_EN
            chk("rnd_stallcnt", 32'(StallCount), 32'(m_stalls));
            chk("rnd_flushcnt", 32'(FlushCount), 32'(m_flushes));
`endif
        end

`ifdef IDEX_PERF_CNT_EN
        // Drive 0x10000 hazard bubbles; the stall counter must saturate.
        Rst = 1'b1; #1; Rst = 1'b0;
        for (int s = 0; s < 32'h10000; s++) begin
            set_in(1, 0, LW, 0, 1, 32'd0);
            @(posedge Clk); #1;
            set_in(1, 0, ADD, 1, 0, 32'd0);
            @(posedge Clk); #1;
        end
        chk("sat_stallcnt", 32'(StallCount), 32'hFFFF);
        chk("sat_flushcnt", 32'(FlushCount), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/idex_pipeline_stage.md
# idex_pipeline_stage

ID/EX pipeline register for the five-stage datapath, with integrated load-use hazard detection. It latches the decoded control bundle produced by the datapath controller along with register operands and the immediate. It inserts a bubble on a load-use hazard or a branch/jump flush, and drives the PC and IF/ID write enables so that the decode-stage instruction is replayed.

## Interface
Parameters:
- DATA_W, 32, operand/PC/immediate width
- REG_ADDR_W, 5, register specifier width

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous, active-high reset
- WriteEnable  in  1  stage write enable (controller StageWriteEnable bit 0); 0 = hold
- Flush  in  1  branch/jump redirect; squash the decode-stage instruction
- CtrlIn  in  18  packed control, MSB→LSB: Jump, JumpMux, Branch, MemRead, MemWrite, RegWrite, AluSrc, RegDest[1:0], MemToReg[1:0], ByteSel[1:0], AluOp[4:0]
- PCPlus4In  in  DATA_W  PC+4 of decode instruction
- ReadData1In, ReadData2In  in  DATA_W each  register file outputs
- ImmIn  in  DATA_W  extended immediate
- RsIn, RtIn, RdIn  in  REG_ADDR_W each  decode register specifiers
- CtrlOut  out  18  registered control, same packing
- PCPlus4Out, ReadData1Out, ReadData2Out, ImmOut  out  DATA_W each  registered data
- RsOut, RtOut, RdOut  out  REG_ADDR_W each  registered specifiers
- ExValid  out  1  1 = EX slot holds a real instruction, 0 = bubble
- Stall  out  1  combinational load-use stall request
- PCWrite, IFIDWrite  out  1 each  combinational, equal to ~Stall
- StallCount, FlushCount  out  16 each  present only with IDEX_PERF_CNT_EN

## Operation
- Hazard = CtrlOut.MemRead & ExValid & (RtOut != 0) & ((RtOut == RsIn) | (RtOut == RtIn)). RtIn is compared unconditionally (conservative).
- Stall = Hazard & WriteEnable & ~Flush.
- Per-edge priority, highest first:
  - Flush=1: CtrlOut←0, ExValid←0. Data fields are don't-care and load inputs.
  - WriteEnable=0: all registers hold.
  - Stall=1: bubble. CtrlOut←0, ExValid←0, data fields hold.
  - Otherwise: load all inputs and set ExValid←1.
- State machine (ExValid plus bubble cause), states RUN and BUBBLE:
  - RUN→BUBBLE on any edge where Stall or Flush inserts a bubble.
  - BUBBLE→RUN on the next normal load.
  - In BUBBLE, Hazard is 0 because CtrlOut.MemRead is 0, so exactly one bubble is inserted per load-use hazard.
- All-zero CtrlOut is a legal no-op: no RegWrite, no MemWrite, no MemRead, no Branch, no Jump.
- Specifier 0 ($zero) never raises a hazard.

## Timing
- Registered outputs update on the rising Clk edge. Latency from ID inputs to outputs is 1 cycle.
- Stall, PCWrite and IFIDWrite are combinational from registered EX state and the current ID specifiers, within the same cycle.
- Reset (asynchronous, immediate): every registered output is 0, including ExValid. This gives Stall=0 and PCWrite=IFIDWrite=1.
- Reset asserted mid-stall clears the bubble state. The first edge after deassertion performs a normal load.
- Flush and Hazard in the same cycle: Flush wins and Stall=0, so IF/ID is free to take the redirect target.
- Hazard with WriteEnable=0: Stall=0 and everything holds. The hazard is re-evaluated once the stage is enabled.

## Configuration
- IDEX_PERF_CNT_EN defined:
  - StallCount increments on every edge that inserts a hazard bubble.
  - FlushCount increments on every edge that performs a flush.
  - Both are 16-bit, saturate at 0xFFFF, and are cleared by Rst.
- IDEX_PERF_CNT_EN undefined: both counters and their ports are absent; all other behaviour is identical.

## Test plan
- Reset: assert Rst with random inputs → all outputs 0, ExValid=0, PCWrite=IFIDWrite=1. Release, load CtrlIn=ADDI bundle, ReadData1In=0x0000_0005 → next edge CtrlOut equals input, ExValid=1.
- Load-use: load LW with Rt=8, then present RsIn=8 → Stall=1 and PCWrite=0 that cycle. Next edge CtrlOut=0, ExValid=0, Stall=0. The following edge loads the dependent instruction.
- $zero: LW with Rt=0 followed by RsIn=0 → Stall=0, no bubble.
- Flush plus hazard together: LW Rt=3 in EX, RtIn=3, Flush=1 → Stall=0, next edge CtrlOut=0, ExValid=0.
- Hold: WriteEnable=0 for 3 cycles with changing inputs → outputs unchanged. With the macro on, a saturation test forces 0x10000 stalls → StallCount=0xFFFF.
